fsk_frame_serdes: RTL and testbench

// Parametrised successor to the fixed 16-bit / 1-bit / 256-clock symbol timing, bit write and bit read path.

---
 rtl/fsk_frame_serdes.sv | 157 +++++++++++++++
 tb/tb_fsk_frame_serdes.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fsk_frame_serdes.sv
// fsk_frame_serdes: symbol timing, frame-to-symbol serialiser (TX) and
// mid-symbol sampling symbol-to-frame deserialiser (RX) for an FSK link.
module fsk_frame_serdes #(
  parameter  int FRAME_W   = 16,
  parameter  int BPS       = 2,
  parameter  int SPS       = 256,
  parameter  int MSB_FIRST = 0,
  localparam int NSYM      = FRAME_W / BPS,
  localparam int PW        = $clog2(SPS),
  localparam int SW        = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [BPS-1:0]     tx_sym,
  output logic               tx_active,
  output logic               sym_strobe,
  output logic [PW-1:0]      phase,
  output logic [SW-1:0]      sym_cnt,
  input  logic               rx_en,
  input  logic [BPS-1:0]     rx_sym,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid
);

  typedef enum logic [1:0] {IDLE, ARMED, SEND} tx_state_e;

  tx_state_e          state_q;
  logic [PW-1:0]      phase_q;
  logic [SW-1:0]      sym_cnt_q;
  logic [BPS-1:0]     tx_sym_q;
  logic               tx_active_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [BPS-1:0]     sym_head;
  logic [FRAME_W-1:0] shift_next;

  logic [SW-1:0]      rx_idx_q;
  logic [FRAME_W-1:0] rx_acc_q;
  logic [FRAME_W-1:0] rx_acc_d;
  logic [FRAME_W-1:0] rx_data_q;
  logic               rx_valid_q;

  logic end_edge;
  logic mid_edge;

  assign end_edge   = (phase_q == PW'(SPS - 1));
  assign mid_edge   = (phase_q == PW'(SPS / 2));
  assign sym_strobe = (phase_q == '0);
  assign phase      = phase_q;
  assign sym_cnt    = sym_cnt_q;
  assign tx_sym     = tx_sym_q;
  assign tx_active  = tx_active_q;
  assign tx_ready   = (state_q == IDLE) & rst_n;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

  // Next symbol always sits at the head of the shift register; the
  // shift direction follows the symbol ordering.
  if (MSB_FIRST != 0) begin : g_msb
    assign sym_head   = shreg_q[FRAME_W-1 -: BPS];
    assign shift_next = shreg_q << BPS;
  end else begin : g_lsb
    assign sym_head   = shreg_q[BPS-1:0];
    assign shift_next = shreg_q >> BPS;
  end

  // Free-running symbol phase counter, never stalled.
  always_ff @(posedge clk_sys) begin
    if (!rst_n)        phase_q <= '0;
    else if (end_edge) phase_q <= '0;
    else               phase_q <= phase_q + PW'(1);
  end

  // TX FSM: latch at handshake, then advance symbols only at end edges.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_sym_q    <= '0;
      tx_active_q <= 1'b0;
      sym_cnt_q   <= '0;
      shreg_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shreg_q <= tx_data;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (end_edge) begin
            tx_sym_q    <= sym_head;
            shreg_q     <= shift_next;
            tx_active_q <= 1'b1;
            sym_cnt_q   <= '0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (end_edge) begin
            if (sym_cnt_q == SW'(NSYM - 1)) begin
              tx_sym_q    <= '0;
              tx_active_q <= 1'b0;
              sym_cnt_q   <= '0;
              state_q     <= IDLE;
            end else begin
              sym_cnt_q <= sym_cnt_q + SW'(1);
              tx_sym_q  <= sym_head;
              shreg_q   <= shift_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Drop the received symbol into its slot of the assembly word.
  always_comb begin
    rx_acc_d = rx_acc_q;
    for (int k = 0; k < NSYM; k++) begin
      if (rx_idx_q == SW'(k)) begin
        if (MSB_FIRST != 0) rx_acc_d[FRAME_W-1-k*BPS -: BPS] = rx_sym;
        else                rx_acc_d[k*BPS +: BPS]           = rx_sym;
      end
    end
  end

  // RX assembly: mid-symbol sampling, frame publish on the last symbol.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      rx_idx_q   <= '0;
      rx_acc_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!rx_en) begin
        rx_idx_q <= '0;
        rx_acc_q <= '0;
      end else if (mid_edge) begin
        if (rx_idx_q == SW'(NSYM - 1)) begin
          rx_data_q  <= rx_acc_d;
          rx_valid_q <= 1'b1;
          rx_idx_q   <= '0;
          rx_acc_q   <= '0;
        end else begin
          rx_acc_q <= rx_acc_d;
          rx_idx_q <= rx_idx_q + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_frame_serdes.sv
// Directed bench for fsk_frame_serdes: three instances (LSB-first 2-bit,
// MSB-first 2-bit, LSB-first 4-bit) sharing clock and reset, SPS=8.
module tb_fsk_frame_serdes;
  logic clk;
  logic rst_n;
  logic lb;
  int   n_vec;
  int   n_err;

  // dut0: BPS=2, LSB first
  logic [15:0] tx_data0;
  logic        tx_valid0, tx_ready0, tx_active0, sym_strobe0, rx_valid0;
  logic [1:0]  tx_sym0, rx_sym0, rx_sym0_drv;
  logic [2:0]  phase0, sym_cnt0;
  logic        rx_en0, rx_en0_drv;
  logic [15:0] rx_data0;
  // dut1: BPS=2, MSB first
  logic [15:0] tx_data1;
  logic        tx_valid1, tx_ready1, tx_active1, sym_strobe1, rx_valid1, rx_en1;
  logic [1:0]  tx_sym1, rx_sym1;
  logic [2:0]  phase1, sym_cnt1;
  logic [15:0] rx_data1;
  // dut2: BPS=4, LSB first, always looped back
  logic [15:0] tx_data2;
  logic        tx_valid2, tx_ready2, tx_active2, sym_strobe2, rx_valid2;
  logic [3:0]  tx_sym2;
  logic [2:0]  phase2;
  logic [1:0]  sym_cnt2;
  logic [15:0] rx_data2;

  assign rx_sym0 = lb ? tx_sym0    : rx_sym0_drv;
  assign rx_en0  = lb ? tx_active0 : rx_en0_drv;

  fsk_frame_serdes #(.FRAME_W(16), .BPS(2), .SPS(8), .MSB_FIRST(0)) dut0 (
    .clk_sys(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_sym(tx_sym0), .tx_active(tx_active0),
    .sym_strobe(sym_strobe0), .phase(phase0), .sym_cnt(sym_cnt0),
    .rx_en(rx_en0), .rx_sym(rx_sym0), .rx_data(rx_data0), .rx_valid(rx_valid0));

  fsk_frame_serdes #(.FRAME_W(16), .BPS(2), .SPS(8), .MSB_FIRST(1)) dut1 (
    .clk_sys(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_sym(tx_sym1), .tx_active(tx_active1),
    .sym_strobe(sym_strobe1), .phase(phase1), .sym_cnt(sym_cnt1),
    .rx_en(rx_en1), .rx_sym(rx_sym1), .rx_data(rx_data1), .rx_valid(rx_valid1));

  fsk_frame_serdes #(.FRAME_W(16), .BPS(4), .SPS(8), .MSB_FIRST(0)) dut2 (
    .clk_sys(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_sym(tx_sym2), .tx_active(tx_active2),
    .sym_strobe(sym_strobe2), .phase(phase2), .sym_cnt(sym_cnt2),
    .rx_en(tx_active2), .rx_sym(tx_sym2), .rx_data(rx_data2), .rx_valid(rx_valid2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  exp0 [8];
  logic [1:0]  exp1 [8];
  logic [3:0]  exp2 [4];
  int          np0, np2;
  logic [15:0] cap0, cap2;

  initial begin
    exp0 = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
    exp1 = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    exp2 = '{4'hA, 4'h5, 4'hC, 4'h3};
    n_vec = 0; n_err = 0;
    clk = 0; rst_n = 0; lb = 0;
    tx_data0 = '0; tx_valid0 = 0; rx_sym0_drv = '0; rx_en0_drv = 0;
    tx_data1 = '0; tx_valid1 = 0; rx_sym1 = '0; rx_en1 = 0;
    tx_data2 = '0; tx_valid2 = 0;
    np0 = 0; np2 = 0; cap0 = '0; cap2 = '0;

    // reset held three clocks
    repeat (3) @(negedge clk);
    chk("rst_phase0", 32'(phase0), 0);
    chk("rst_phase1", 32'(phase1), 0);
    chk("rst_phase2", 32'(phase2), 0);
    chk("rst_tx_sym0", 32'(tx_sym0), 0);
    chk("rst_tx_active0", 32'(tx_active0), 0);
    chk("rst_tx_ready0", 32'(tx_ready0), 0);
    chk("rst_tx_ready2", 32'(tx_ready2), 0);
    chk("rst_sym_cnt0", 32'(sym_cnt0), 0);
    chk("rst_rx_data0", 32'(rx_data0), 0);
    chk("rst_rx_valid0", 32'(rx_valid0), 0);
    chk("rst_strobe1", 32'(sym_strobe1), 1);
    chk("rst_strobe2", 32'(sym_strobe2), 1);
    rst_n = 1;
    #1 chk("rel_tx_ready0", 32'(tx_ready0), 1);

    // free-running phase and strobe
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("phase_count", 32'(phase0), 32'(i % 8));
      chk("sym_strobe", 32'(sym_strobe0), ((i % 8) == 0) ? 32'd1 : 32'd0);
    end

    // TX on all three, loopback RX on dut0 and dut2
    lb = 1;
    tx_data0 = 16'hB4E1; tx_data1 = 16'hB4E1; tx_data2 = 16'h3C5A;
    tx_valid0 = 1; tx_valid1 = 1; tx_valid2 = 1;
    @(negedge clk);
    tx_data0 = 16'h1234;  // junk with valid held: must be ignored
    tx_valid1 = 0; tx_valid2 = 0;
    chk("hs_tx_ready0", 32'(tx_ready0), 0);
    chk("hs_tx_ready1", 32'(tx_ready1), 0);
    chk("armed_active0", 32'(tx_active0), 0);
    for (int n = 0; n < 20 && !tx_active0; n++) @(negedge clk);
    chk("start_active0", 32'(tx_active0), 1);
    chk("start_phase0", 32'(phase0), 0);
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 8; c++) begin
        if (k == 4 && c == 0) tx_valid0 = 0;
        if (k < 8) begin
          chk("tx_sym0", 32'(tx_sym0), 32'(exp0[k]));
          chk("tx_sym1", 32'(tx_sym1), 32'(exp1[k]));
          chk("tx_active0", 32'(tx_active0), 1);
          chk("sym_cnt1", 32'(sym_cnt1), 32'(k));
        end else begin
          chk("end_active0", 32'(tx_active0), 0);
          chk("end_tx_sym0", 32'(tx_sym0), 0);
        end
        if (k < 4) begin
          chk("tx_sym2", 32'(tx_sym2), 32'(exp2[k]));
          chk("sym_cnt2", 32'(sym_cnt2), 32'(k));
        end else begin
          chk("end_active2", 32'(tx_active2), 0);
        end
        if (rx_valid0) begin np0++; cap0 = rx_data0; end
        if (rx_valid2) begin np2++; cap2 = rx_data2; end
        @(negedge clk);
      end
    end
    chk("lb_pulses0", 32'(np0), 1);
    chk("lb_data0", 32'(cap0), 32'h0000B4E1);
    chk("lb_pulses2", 32'(np2), 1);
    chk("lb_data2", 32'(cap2), 32'h00003C5A);
    chk("after_ready0", 32'(tx_ready0), 1);
    chk("after_ready2", 32'(tx_ready2), 1);
    chk("rx_idle1", 32'(rx_valid1), 0);
    chk("rx_data_idle1", 32'(rx_data1), 0);

    // RX abort after a partial frame, then a full frame
    lb = 0; rx_en0_drv = 0;
    for (int n = 0; n < 16 && phase0 != 3'd0; n++) @(negedge clk);
    chk("align_phase0", 32'(phase0), 0);
    chk("rx_hold0", 32'(rx_data0), 32'h0000B4E1);
    rx_en0_drv = 1;
    np0 = 0;
    for (int s = 0; s < 4; s++) begin
      rx_sym0_drv = (s < 3) ? 2'd3 : 2'd0;
      if (s == 3) rx_en0_drv = 0;
      repeat (8) begin
        @(negedge clk);
        if (rx_valid0) np0++;
      end
    end
    chk("partial_no_pulse", 32'(np0), 0);
    rx_en0_drv = 1;
    for (int s = 0; s < 8; s++) begin
      rx_sym0_drv = ((s % 4) < 2) ? 2'd3 : 2'd0;
      repeat (8) begin
        @(negedge clk);
        if (rx_valid0) begin np0++; cap0 = rx_data0; end
      end
    end
    rx_en0_drv = 0;
    repeat (10) @(negedge clk);
    chk("full_pulses", 32'(np0), 1);
    chk("full_data", 32'(cap0), 32'h00000F0F);
    chk("full_hold", 32'(rx_data0), 32'h00000F0F);

    // reset during TX symbol 4
    tx_data0 = 16'hFFFF; tx_valid0 = 1;
    @(negedge clk);
    tx_valid0 = 0;
    for (int n = 0; n < 20 && !tx_active0; n++) @(negedge clk);
    chk("r6_start", 32'(tx_active0), 1);
    repeat (34) @(negedge clk);
    chk("r6_sym4", 32'(tx_sym0), 3);
    chk("r6_cnt4", 32'(sym_cnt0), 4);
    rst_n = 0;
    @(negedge clk);
    chk("r6_tx_sym", 32'(tx_sym0), 0);
    chk("r6_active", 32'(tx_active0), 0);
    chk("r6_cnt", 32'(sym_cnt0), 0);
    chk("r6_phase", 32'(phase0), 0);
    chk("r6_ready_in_rst", 32'(tx_ready0), 0);
    rst_n = 1;
    #1 chk("r6_ready", 32'(tx_ready0), 1);
    @(negedge clk);
    tx_data0 = 16'hB4E1; tx_valid0 = 1;
    @(negedge clk);
    tx_valid0 = 0;
    for (int n = 0; n < 20 && !tx_active0; n++) @(negedge clk);
    chk("r6b_start", 32'(tx_active0), 1);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 8; c++) begin
        chk("r6b_sym", 32'(tx_sym0), 32'(exp0[k]));
        chk("r6b_cnt", 32'(sym_cnt0), 32'(k));
        @(negedge clk);
      end
    end
    chk("r6b_end_active", 32'(tx_active0), 0);
    chk("r6b_end_ready", 32'(tx_ready0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
